// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers for the multiply/divide engine.
// Holds the op encodings, the FSM state encoding and the divider iteration count.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int         DIV_ITERS = 32;
   localparam logic [4:0] DIV_LAST  = 5'(DIV_ITERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DIV  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   // Magnitude of a 32-bit value; only negates when the operation is signed.
   // The magnitude of 32'h8000_0000 is 32'h8000_0000 read as unsigned.
   function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
      if (sgn && v[31]) begin
         abs32 = ~v + 32'd1;
      end else begin
         abs32 = v;
      end
   endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// div_core: restoring radix-2 divider on operand magnitudes.
// A start pulse loads the operands; 32 iterations follow (counter 0..31) and
// valid is high during the last iteration, when quotient/remainder carry the
// sign-corrected final result. abort drops any division in flight.
module div_core
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        is_signed,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        valid,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] dvs_r;
   logic [31:0] raw_a_r;
   logic [4:0]  cnt_r;
   logic        run_r;
   logic        neg_q_r;
   logic        neg_r_r;
   logic        div_zero_r;

   logic [32:0] partial_s;
   logic [32:0] diff_s;
   logic [31:0] rem_next_s;
   logic [31:0] quo_next_s;
   logic        q_bit_s;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      partial_s  = {rem_r, quo_r[31]};
      diff_s     = partial_s - {1'b0, dvs_r};
      rem_next_s = partial_s[31:0];
      q_bit_s    = 1'b0;
      if (!diff_s[32]) begin
         rem_next_s = diff_s[31:0];
         q_bit_s    = 1'b1;
      end else begin
         rem_next_s = partial_s[31:0];
         q_bit_s    = 1'b0;
      end
      quo_next_s = {quo_r[30:0], q_bit_s};
   end

   // Sign fixup of the final step; a zero divisor yields all-ones / dividend.
   always_comb begin
      quotient  = quo_next_s;
      remainder = rem_next_s;
      if (div_zero_r) begin
         quotient  = 32'hFFFF_FFFF;
         remainder = raw_a_r;
      end else begin
         quotient  = neg_q_r ? (~quo_next_s + 32'd1) : quo_next_s;
         remainder = neg_r_r ? (~rem_next_s + 32'd1) : rem_next_s;
      end
   end

   assign valid = run_r && (cnt_r == DIV_LAST);

   // Operand load on start, then one iteration per cycle until the counter wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r      <= 32'd0;
         quo_r      <= 32'd0;
         dvs_r      <= 32'd0;
         raw_a_r    <= 32'd0;
         cnt_r      <= 5'd0;
         run_r      <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         div_zero_r <= 1'b0;
      end else if (abort) begin
         run_r <= 1'b0;
         cnt_r <= 5'd0;
      end else if (start) begin
         rem_r      <= 32'd0;
         quo_r      <= abs32(dividend, is_signed);
         dvs_r      <= abs32(divisor, is_signed);
         raw_a_r    <= dividend;
         cnt_r      <= 5'd0;
         run_r      <= 1'b1;
         neg_q_r    <= is_signed & (dividend[31] ^ divisor[31]);
         neg_r_r    <= is_signed & dividend[31];
         div_zero_r <= (divisor == 32'd0);
      end else if (run_r) begin
         rem_r <= rem_next_s;
         quo_r <= quo_next_s;
         cnt_r <= cnt_r + 5'd1;
         if (cnt_r == DIV_LAST) begin
            run_r <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle MULT/MULTU/DIV/DIVU engine driving the HI/LO writes.
// FSM IDLE -> MUL|DIV -> DONE -> IDLE; one write to each HILO register in DONE.
// Optional build macro MULDIV_DIVZERO_FAST_EN: a divide with a zero divisor
// skips the iterations and goes straight from IDLE to DONE.
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic        hi_we,
   output logic [31:0] hi_wd,
   output logic        lo_we,
   output logic [31:0] lo_wd
);

   state_t      state_r;
   logic [1:0]  op_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [31:0] hi_res_r;
   logic [31:0] lo_res_r;

   logic        accept_s;
   logic        div_fast_s;
   logic        div_start_s;
   logic        write_s;
   logic [63:0] mul_a_s;
   logic [63:0] mul_b_s;
   logic [63:0] product_s;
   logic        div_valid_s;
   logic [31:0] div_quo_s;
   logic [31:0] div_rem_s;

   assign accept_s = (state_r == ST_IDLE) && start && !cancel && !rst;

`ifdef MULDIV_DIVZERO_FAST_EN
   assign div_fast_s = (b == 32'd0);
`else
   assign div_fast_s = 1'b0;
`endif

   assign div_start_s = accept_s && op[1] && !div_fast_s;

   div_core u_div_core (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start_s),
      .abort     (cancel),
      .is_signed (!op[0]),
      .dividend  (a),
      .divisor   (b),
      .valid     (div_valid_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // 64-bit product: sign- or zero-extend so one unsigned multiply serves both.
   always_comb begin
      mul_a_s = {32'd0, a_r};
      mul_b_s = {32'd0, b_r};
      if (op_r == OP_MULT) begin
         mul_a_s = {{32{a_r[31]}}, a_r};
         mul_b_s = {{32{b_r[31]}}, b_r};
      end else begin
         mul_a_s = {32'd0, a_r};
         mul_b_s = {32'd0, b_r};
      end
      product_s = mul_a_s * mul_b_s;
   end

   // Control FSM with operand latch and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         op_r     <= 2'b00;
         a_r      <= 32'd0;
         b_r      <= 32'd0;
         hi_res_r <= 32'd0;
         lo_res_r <= 32'd0;
      end else if (cancel) begin
         state_r <= ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  op_r <= op;
                  a_r  <= a;
                  b_r  <= b;
                  if (!op[1]) begin
                     state_r <= ST_MUL;
                  end else if (div_fast_s) begin
                     hi_res_r <= a;
                     lo_res_r <= 32'hFFFF_FFFF;
                     state_r  <= ST_DONE;
                  end else begin
                     state_r <= ST_DIV;
                  end
               end
            end
            ST_MUL: begin
               hi_res_r <= product_s[63:32];
               lo_res_r <= product_s[31:0];
               state_r  <= ST_DONE;
            end
            ST_DIV: begin
               if (div_valid_s) begin
                  hi_res_r <= div_rem_s;
                  lo_res_r <= div_quo_s;
                  state_r  <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // A cancel or reset landing in DONE suppresses the write in that same cycle.
   assign write_s = (state_r == ST_DONE) && !cancel && !rst;
   assign busy    = accept_s || (!rst && ((state_r == ST_MUL) || (state_r == ST_DIV)));
   assign done    = write_s;
   assign hi_we   = write_s;
   assign lo_we   = write_s;
   assign hi_wd   = write_s ? hi_res_r : 32'd0;
   assign lo_wd   = write_s ? lo_res_r : 32'd0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic        hi_we;
   logic [31:0] hi_wd;
   logic        lo_we;
   logic [31:0] lo_wd;

   int tests = 0;
   int fails = 0;

`ifdef MULDIV_DIVZERO_FAST_EN
   localparam int DIV0_CYC = 1;
`else
   localparam int DIV0_CYC = 33;
`endif

   muldiv_unit dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .cancel (cancel),
      .busy   (busy),
      .done   (done),
      .hi_we  (hi_we),
      .hi_wd  (hi_wd),
      .lo_we  (lo_we),
      .lo_wd  (lo_wd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation in cycle 0 and watch cycles 1..40.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input int exp_cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          done_cyc = 0;
      int          done_cnt = 0;
      int          busy_cnt = 0;
      int          en_bad   = 0;
      int          wd_bad   = 0;
      logic [31:0] got_hi   = 32'd0;
      logic [31:0] got_lo   = 32'd0;
      op = o; a = x; b = y; start = 1'b1;
      #1;
      check({tag, " busy0"}, {63'd0, busy}, 64'd1);
      next_cycle();
      start = 1'b0; a = 32'd0; b = 32'd0;
      for (int c = 1; c <= 40; c++) begin
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = c;
            got_hi   = hi_wd;
            got_lo   = lo_wd;
         end else if (hi_wd !== 32'd0 || lo_wd !== 32'd0) begin
            wd_bad++;
         end
         if (hi_we !== done || lo_we !== done) en_bad++;
         if (busy === 1'b1) busy_cnt++;
         next_cycle();
      end
      check({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
      check({tag, " done_count"}, 64'(done_cnt), 64'd1);
      check({tag, " hi"}, {32'd0, got_hi}, {32'd0, exp_hi});
      check({tag, " lo"}, {32'd0, got_lo}, {32'd0, exp_lo});
      check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_cyc - 1));
      check({tag, " we_eq_done"}, 64'(en_bad), 64'd0);
      check({tag, " wd_idle_zero"}, 64'(wd_bad), 64'd0);
   endtask

   initial begin
      int          busy_bad;
      int          we_cnt;
      int          done_cyc;
      logic [31:0] got_lo;
      logic [9:0]  trace;

      rst = 1'b1; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0; cancel = 1'b0;
      next_cycle();
      next_cycle();
      check("reset outputs", {busy, done, hi_we, lo_we, hi_wd, lo_wd}, 68'd0);
      rst = 1'b0;
      next_cycle();
      check("idle outputs", {busy, done, hi_we, lo_we, hi_wd, lo_wd}, 68'd0);

      run_op("mult_m1x2",  2'b00, 32'hFFFF_FFFF, 32'd2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run_op("multu_m1x2", 2'b01, 32'hFFFF_FFFF, 32'd2, 2, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("mult_m3x5",  2'b00, 32'hFFFF_FFFD, 32'd5, 2, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("div_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
      run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("divu_big",   2'b11, 32'hFFFF_FFFF, 32'h10, 33, 32'hF, 32'h0FFF_FFFF);
      run_op("div_5_0",    2'b10, 32'd5, 32'd0, DIV0_CYC, 32'd5, 32'hFFFF_FFFF);
      run_op("div_m5_0",   2'b10, 32'hFFFF_FFFB, 32'd0, DIV0_CYC, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      run_op("divu_x_0",   2'b11, 32'hDEAD_BEEF, 32'd0, DIV0_CYC, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
      run_op("div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);

      // DIVU cancelled in cycle 10: busy drops in cycle 11, no write ever.
      op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
      next_cycle();
      start = 1'b0;
      busy_bad = 0; we_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         cancel = (c == 10);
         #1;
         if (busy !== ((c <= 10) ? 1'b1 : 1'b0)) busy_bad++;
         if (hi_we !== 1'b0 || lo_we !== 1'b0 || done !== 1'b0) we_cnt++;
         next_cycle();
      end
      cancel = 1'b0;
      check("cancel busy profile", 64'(busy_bad), 64'd0);
      check("cancel no write", 64'(we_cnt), 64'd0);

      // A second start in cycle 5 of a DIVU is ignored.
      op = 2'b11; a = 32'd1000; b = 32'd10; start = 1'b1;
      next_cycle();
      start = 1'b0;
      done_cyc = 0; got_lo = 32'd0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5) begin
            op = 2'b00; a = 32'd3; b = 32'd3; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         #1;
         if (done === 1'b1 && done_cyc == 0) begin
            done_cyc = c;
            got_lo   = lo_wd;
         end
         next_cycle();
      end
      start = 1'b0;
      check("restart ignored cycle", 64'(done_cyc), 64'd33);
      check("restart ignored lo", {32'd0, got_lo}, 64'd100);

      // Cancel arriving in DONE gates the write that cycle.
      op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
      next_cycle();
      start = 1'b0;
      next_cycle();
      cancel = 1'b1;
      #1;
      check("cancel in done", {done, hi_we, lo_we, hi_wd, lo_wd}, 67'd0);
      next_cycle();
      cancel = 1'b0;
      next_cycle();
      check("after cancel idle", {busy, done}, 64'd0);

      // Cancel has priority over start in IDLE.
      op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1; cancel = 1'b1;
      #1;
      check("cancel beats start busy", {63'd0, busy}, 64'd0);
      next_cycle();
      start = 1'b0; cancel = 1'b0;
      we_cnt = 0;
      for (int c = 1; c <= 4; c++) begin
         if (done !== 1'b0 || busy !== 1'b0) we_cnt++;
         next_cycle();
      end
      check("cancel beats start quiet", 64'(we_cnt), 64'd0);

      // Held start: accepted again only in the cycle after DONE.
      op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
      next_cycle();
      trace = 10'd0;
      for (int c = 1; c <= 5; c++) begin
         trace = {trace[7:0], busy, done};
         next_cycle();
      end
      start = 1'b0;
      // cycles 1..5 as {busy,done}: 10 01 10 10 01
      check("back_to_back trace", {54'd0, trace}, {54'd0, 10'b10_01_10_10_01});
      next_cycle();
      next_cycle();

      // Reset in cycle 3 of a DIV discards it.
      op = 2'b10; a = 32'd50; b = 32'd5; start = 1'b1;
      next_cycle();
      start = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      check("reset mid div outputs", {busy, done, hi_we, lo_we, hi_wd, lo_wd}, 68'd0);
      we_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         if (hi_we !== 1'b0 || lo_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) we_cnt++;
         next_cycle();
      end
      check("reset mid div quiet", 64'(we_cnt), 64'd0);
      run_op("mult_after_rst", 2'b00, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide engine that produces the HI/LO write traffic for the CPU's two HILO registers. It executes MULT, MULTU, DIV and DIVU, stalls the pipeline while busy, and issues one write to each HILO register when the result is ready. It sits in the execute stage: the decoder drives `start`/`op`, the hazard unit consumes `busy`, and `hi_we/hi_wd` and `lo_we/lo_wd` connect directly to the `we/wd` inputs of the HI and LO instances.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 64-bit result.
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`
- a  in  32  rs operand (multiplicand / dividend)
- b  in  32  rt operand (multiplier / divisor)
- cancel  in  1  exception flush; aborts any operation in flight
- busy  out  1  pipeline stall request
- done  out  1  one-cycle pulse in the result cycle
- hi_we  out  1  HI register write enable
- hi_wd  out  32  HI write data
- lo_we  out  1  LO register write enable
- lo_wd  out  32  LO write data

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE + start + !cancel: latch `op`, `a` and `b`, then go to MUL (op[1]=0) or DIV (op[1]=1).
- MUL: compute the 64-bit product (signed for MULT, unsigned for MULTU), register it, then go to DONE.
- DIV: restoring radix-2 division on absolute values. It takes 32 iterations with a counter running 0..31, then goes to DONE.
- DIV sign fixup (DIV only):
  - quotient is negated when a[31]^b[31];
  - remainder takes the sign of the dividend.
- DIV result placement: LO = quotient, HI = remainder.
- DIV special cases:
  - divisor 0 (both DIV and DIVU): LO = 32'hFFFF_FFFF, HI = a.
  - 32'h8000_0000 / 32'hFFFF_FFFF (DIV): LO = 32'h8000_0000, HI = 0.
- MUL result placement: HI = product[63:32], LO = product[31:0].
- DONE: assert hi_we = lo_we = done = 1 with the result on hi_wd/lo_wd, then return to IDLE.
- Outputs in all other states: we and done are 0, and wd holds 0.
- `start` while not in IDLE is ignored; the decoder keeps the request held under stall.
- `cancel`:
  - In any state, the next state is IDLE.
  - No write occurs, including when `cancel` arrives in DONE, where we are gated off combinationally.
  - `cancel` has priority over `start` in the same cycle.
- `rst`: next state is IDLE, the counter and operand/result registers clear to 0, and all outputs are 0.
- `rst` mid-operation discards the result with no write.

## Timing
- busy = (state==IDLE && start && !cancel) || state==MUL || state==DIV.
  - busy is 0 in DONE, so the stalled instruction advances in the write cycle.
- Cycle numbering below counts the start cycle as 0.
- MULT/MULTU latency: MUL in cycle 1, DONE in cycle 2.
- DIV/DIVU latency: DIV in cycles 1..32, DONE in cycle 33.
- A back-to-back `start` is accepted in the cycle after DONE (IDLE), never during DONE.
- HILO registers capture hi_wd/lo_wd during the DONE cycle; `done` and the write enables are high for exactly one cycle.

## Configuration
- `MULDIV_DIVZERO_FAST_EN` defined: a DIV/DIVU with b == 0 goes directly IDLE → DONE and writes the divide-by-zero result in cycle 1. busy is high in cycle 0 only.
- `MULDIV_DIVZERO_FAST_EN` undefined: a divisor of 0 runs the full 32 iterations (DONE in cycle 33) and produces the same HI/LO values.

## Structure
- Shared package `muldiv_pkg` holds:
  - op encodings OP_MULT/OP_MULTU/OP_DIV/OP_DIVU;
  - state encoding;
  - DIV_ITERS = 32.
- Sub-module `div_core` holds the restoring-divider datapath (partial remainder, quotient shift, iteration counter, sign fixup) with a start/valid handshake.
- The top level contains the FSM, the multiplier, result muxing and the write outputs.

## Test plan
- MULT a=32'hFFFF_FFFF, b=2 → cycle 2: HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE, hi_we=lo_we=done=1 for one cycle.
- MULTU a=32'hFFFF_FFFF, b=2 → cycle 2: HI=1, LO=32'hFFFF_FFFE; busy high in cycles 0–1 only.
- DIV a=-7, b=2 → cycle 33: LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. DIVU a=100, b=7 → LO=14, HI=2.
- DIV a=5, b=0 → LO=32'hFFFF_FFFF, HI=5; done in cycle 1 with `MULDIV_DIVZERO_FAST_EN`, cycle 33 without. DIV 32'h8000_0000/32'hFFFF_FFFF → LO=32'h8000_0000, HI=0.
- DIVU started, `cancel` in cycle 10 → busy low from cycle 11, no we pulse through cycle 40. A second `start` in cycle 5 of any op is ignored.
- `rst` asserted in cycle 3 of a DIV → all outputs 0 the next cycle, no write. A new MULT after reset completes normally.
